// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a combinational fetch port and a synchronous programming port.
// Define IMEM_PRELOAD_EN to make the power-up/reset image a four-instruction smoke program instead of all NOPs.
module instruction_memory #(
   parameter int unsigned DEPTH    = 256,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   output logic [31:0] inst,
   output logic        addr_err,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef logic [31:0] image_t [DEPTH];

`ifdef IMEM_PRELOAD_EN
   localparam image_t DEFAULT_IMAGE = '{
      0:       32'h0050_0093,   // addi x1,x0,5
      1:       32'h0030_0113,   // addi x2,x0,3
      2:       32'h0020_81B3,   // add  x3,x1,x2
      3:       32'h4020_8233,   // sub  x4,x1,x2
      default: NOP_INST
   };
`else
   localparam image_t DEFAULT_IMAGE = '{default: NOP_INST};
`endif

   // The core may fetch before any reset, so the array powers up holding the default image.
   image_t mem = DEFAULT_IMAGE;

   logic wr_in_range;

   // Any set bit above the index field means out of range; there is no wrap-around.
   assign addr_err    = |addr[31:AW];
   assign wr_in_range = ~|wr_addr[31:AW];

   assign inst = addr_err ? NOP_INST : mem[addr[AW-1:0]];

   // NOTE: reset reloads every word, which rules out a block-RAM mapping; a mid-program reset must
   // discard loaded code, so the store is deliberately built from resettable registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem <= DEFAULT_IMAGE;
      end else if (wr_en && wr_in_range) begin
         mem[wr_addr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: vector table, directed corner sequences, and
// randomized writes/reads/resets checked against an array model of the instruction store.
module tb_instruction_memory;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] inst;
   logic        addr_err;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [DEPTH];

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] exp_inst;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   instruction_memory #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .inst     (inst),
      .addr_err (addr_err),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] img(input int i);
`ifdef IMEM_PRELOAD_EN
      case (i)
         0:       return 32'h0050_0093;
         1:       return 32'h0030_0113;
         2:       return 32'h0020_81B3;
         3:       return 32'h4020_8233;
         default: return NOP;
      endcase
`else
      return NOP;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) model[i] = img(i);
   endtask

   function automatic logic [31:0] exp_inst(input logic [31:0] a);
      return (a < DEPTH) ? model[a] : NOP;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Drive addr, let the combinational path settle, compare both outputs with the model.
   task automatic check_read(input string name, input logic [31:0] a);
      addr = a;
      #1;
      check(name, inst, exp_inst(a));
      check({name, "_err"}, {31'b0, addr_err}, {31'b0, (a >= DEPTH)});
   endtask

   // One clock edge with the given controls; the model applies the same edge's effect.
   task automatic clock(input logic r, input logic we, input logic [31:0] wa, input logic [31:0] wd);
      reset   = r;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      @(posedge clk);
      if (r) model_reset();
      else if (we && wa < DEPTH) model[wa] = wd;
      #1;
      reset = 1'b0;
      wr_en = 1'b0;
   endtask

   initial begin
      logic [31:0] a, wa, wd, old;
      reset = 1'b0;
      wr_en = 1'b0;
      addr  = '0;
      model_reset();

      // Power-up contents, before any reset; wr_addr/wr_data are still undriven.
      #1;
      for (int i = 0; i < 4; i++) check_read($sformatf("powerup_%0d", i), i);

      // Test 1 and 3 as a vector table, after a reset pulse.
      clock(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 4; i++) vecs.push_back('{$sformatf("reset_img_%0d", i), i, img(i), 1'b0});
      vecs.push_back('{"word_7",      32'd7,        NOP, 1'b0});
      vecs.push_back('{"last_word",   DEPTH - 1,    NOP, 1'b0});
      vecs.push_back('{"depth",       DEPTH,        NOP, 1'b1});
      vecs.push_back('{"depth_plus1", DEPTH + 1,    NOP, 1'b1});
      vecs.push_back('{"upper_bit",   32'h8000_0000, NOP, 1'b1});
      vecs.push_back('{"all_ones",    32'hFFFF_FFFF, NOP, 1'b1});
      foreach (vecs[i]) begin
         addr = vecs[i].a;
         #1;
         check(vecs[i].name, inst, vecs[i].exp_inst);
         check({vecs[i].name, "_err"}, {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
      end

      // Test 2: write word 7 with addr parked on it; old data until the edge, new data after.
      addr    = 32'd7;
      wr_en   = 1'b1;
      wr_addr = 32'd7;
      wr_data = 32'hDEAD_BEEF;
      #1;
      check("wr7_before_edge", inst, NOP);
      clock(1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF);
      check("wr7_after_edge", inst, 32'hDEAD_BEEF);

      // Test 3: out-of-range writes are dropped; word 0 and its alias stay unchanged.
      clock(1'b0, 1'b1, DEPTH, 32'hBAD0_0000);
      clock(1'b0, 1'b1, 32'hFFFF_FF00, 32'hBAD0_0001);
      check_read("oob_write_w0", 32'd0);
      addr = 32'd0;
      #1;
      check("oob_write_w0_img", inst, img(0));

      // Test 4: reset beats a simultaneous write.
      clock(1'b1, 1'b1, 32'd0, 32'h1234_5678);
      addr = 32'd0;
      #1;
      check("reset_beats_write", inst, img(0));
      check_read("reset_clears_w7", 32'd7);

      // Test 5: load every word with its index, read all back, reset restores the image.
      for (int i = 0; i < int'(DEPTH); i++) clock(1'b0, 1'b1, i, i);
      begin
         int errs = 0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            addr = i;
            #1;
            if (inst !== 32'(i)) errs++;
         end
         check("fill_index_errors", errs, 0);
      end
      clock(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < int'(DEPTH); i += 37) check_read($sformatf("refill_reset_%0d", i), i);
      addr = DEPTH - 1;
      #1;
      check("refill_reset_last", inst, img(int'(DEPTH) - 1));

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         int unsigned op = $urandom_range(99);
         wa = ($urandom_range(9) == 0) ? 32'($urandom) : 32'($urandom_range(DEPTH - 1));
         wd = 32'($urandom);
         if (op < 3) begin
            clock(1'b1, 1'b1, wa, wd);
         end else if (op < 70) begin
            addr = wa;
            #1;
            old = exp_inst(wa);
            total++;
            if (inst !== old) begin
               bad++;
               $display("FAIL rnd_pre_write @%08h: got %08h, expected %08h", wa, inst, old);
            end
            clock(1'b0, 1'b1, wa, wd);
         end else begin
            clock(1'b0, 1'b0, wa, wd);
         end
         a = ($urandom_range(7) == 0) ? 32'($urandom) : 32'($urandom_range(DEPTH - 1));
         check_read("rnd_read", a);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
